// File: rtl/sd_slv_wdx.sv
// sd_slv_wdx: SD slave write-data receiver; deserialises DAT[3:0], checks CRC16/end nibble,
// then drives the CRC status token and busy on DAT0.
module sd_slv_wdx #(
   parameter int BLK_BYTES = 512,
   parameter int BUSY_MIN  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [3:0] din,
   input  logic       busy_in,
   output logic [7:0] byte_out,
   output logic       byte_vld,
   output logic       blk_done,
   output logic       crc_err,
   output logic       dout0,
   output logic       doe0,
   output logic       idle
);
   localparam logic [2:0] S_IDLE = 3'd0, S_HUNT = 3'd1, S_DATA = 3'd2, S_CRC = 3'd3,
                          S_END  = 3'd4, S_GAP  = 3'd5, S_STAT = 3'd6, S_BUSY = 3'd7;
   localparam logic [11:0] LAST = 12'(2 * BLK_BYTES - 1);
   localparam logic [11:0] BMIN = 12'(BUSY_MIN);
   // token bits indexed by STAT cycle: 0,0,1,0,1 accepted / 0,1,0,1,1 CRC error
   localparam logic [4:0] TOK_OK = 5'b10100, TOK_ER = 5'b11010;

   logic [2:0]  st_q, st_d;
   logic [11:0] cnt_q, cnt_d;
   logic [3:0]  din_q;
   logic [15:0] crc_q [4];
   logic [15:0] crc_d [4];
   logic        err_q, err_d;
   logic [7:0]  byte_q, byte_d;
   logic        vld_q, vld_d, done_q, done_d, cerr_q, cerr_d;
   logic        drive;
   logic [4:0]  tok;

   function automatic logic [15:0] crc_nx(input logic [15:0] c, input logic b);
      return {c[14:0], 1'b0} ^ ({16{c[15] ^ b}} & 16'h1021);
   endfunction

   // busy is held while the minimum has not elapsed or memory is still programming
   assign drive = (st_q == S_BUSY) && ((cnt_q < BMIN) || busy_in);
   assign tok   = err_q ? TOK_ER : TOK_OK;

   always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q + 12'd1;
      crc_d  = crc_q;
      err_d  = err_q;
      byte_d = byte_q;
      vld_d  = 1'b0;
      done_d = 1'b0;
      cerr_d = 1'b0;
      case (st_q)
         S_IDLE: begin
            cnt_d = '0;
            st_d  = wr_en ? S_HUNT : S_IDLE;
         end
         S_HUNT: begin
            cnt_d = '0;
            err_d = 1'b0;
            for (int i = 0; i < 4; i++) crc_d[i] = '0;
            st_d  = (din_q == 4'h0) ? S_DATA : S_HUNT;
         end
         S_DATA: begin
            for (int i = 0; i < 4; i++) crc_d[i] = crc_nx(crc_q[i], din_q[i]);
            if (cnt_q[0]) begin
               byte_d[3:0] = din_q;
               vld_d       = 1'b1;
            end else
               byte_d[7:4] = din_q;
            if (cnt_q == LAST) begin
               st_d  = S_CRC;
               cnt_d = '0;
            end
         end
         S_CRC: begin
            for (int i = 0; i < 4; i++)
               if (din_q[i] != crc_q[i][~cnt_q[3:0]]) err_d = 1'b1;
            if (cnt_q[3:0] == 4'd15) begin
               st_d  = S_END;
               cnt_d = '0;
            end
         end
         S_END: begin
            done_d = 1'b1;
            cerr_d = err_q | (din_q != 4'hf);
            err_d  = cerr_d;
            st_d   = S_GAP;
            cnt_d  = '0;
         end
         S_GAP: if (cnt_q == 12'd1) begin
            st_d  = S_STAT;
            cnt_d = '0;
         end
         S_STAT: if (cnt_q == 12'd4) begin
            st_d  = err_q ? S_IDLE : S_BUSY;
            cnt_d = '0;
         end
         default: begin
            cnt_d = (cnt_q < BMIN) ? cnt_q + 12'd1 : cnt_q;
            if (!drive) st_d = wr_en ? S_HUNT : S_IDLE;
         end
      endcase
      // dropping wr_en before the status phase abandons the block silently
      if (!wr_en && st_q >= S_HUNT && st_q <= S_END) begin
         st_d   = S_IDLE;
         byte_d = byte_q;
         vld_d  = 1'b0;
         done_d = 1'b0;
         cerr_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q   <= S_IDLE;
         cnt_q  <= '0;
         din_q  <= '0;
         crc_q  <= '{default: '0};
         err_q  <= 1'b0;
         byte_q <= '0;
         vld_q  <= 1'b0;
         done_q <= 1'b0;
         cerr_q <= 1'b0;
      end else begin
         st_q   <= st_d;
         cnt_q  <= cnt_d;
         din_q  <= din;
         crc_q  <= crc_d;
         err_q  <= err_d;
         byte_q <= byte_d;
         vld_q  <= vld_d;
         done_q <= done_d;
         cerr_q <= cerr_d;
      end
   end

   assign byte_out = byte_q;
   assign byte_vld = vld_q;
   assign blk_done = done_q;
   assign crc_err  = cerr_q;
   assign doe0     = (st_q == S_STAT) || drive;
   assign dout0    = (st_q == S_STAT) ? tok[cnt_q[2:0]] : !drive;
   assign idle     = (st_q == S_IDLE);
endmodule

// File: tb/tb_sd_slv_wdx.sv
// tb_sd_slv_wdx: directed bench for sd_slv_wdx with BLK_BYTES=4; inputs change 1 time unit
// after posedge, outputs are sampled on negedge.
module tb_sd_slv_wdx;
   logic       clk = 1'b0;
   logic       rst, wr_en, busy_in;
   logic [3:0] din;
   logic [7:0] byte_out;
   logic       byte_vld, blk_done, crc_err, dout0, doe0, idle;

   int         tests = 0, fails = 0;
   logic [7:0] bq[$];
   logic       tq[$];
   int         nblk = 0, ncerr = 0, nviol = 0;
   logic       prev_oe = 1'b0, rel_dout = 1'b0, rel_idle = 1'b0;

   sd_slv_wdx #(.BLK_BYTES(4), .BUSY_MIN(2)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .busy_in(busy_in),
      .byte_out(byte_out), .byte_vld(byte_vld), .blk_done(blk_done), .crc_err(crc_err),
      .dout0(dout0), .doe0(doe0), .idle(idle)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (byte_vld) bq.push_back(byte_out);
      if (blk_done) nblk++;
      if (crc_err) ncerr++;
      if ((byte_vld && (blk_done || crc_err)) || (crc_err && !blk_done)) nviol++;
      if (doe0) tq.push_back(dout0);
      if (prev_oe && !doe0) begin
         rel_dout = dout0;
         rel_idle = idle;
      end
      prev_oe = doe0;
   end

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
      logic fb;
      fb = c[15] ^ b;
      return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
   endfunction

   task automatic step(input logic [3:0] n);
      @(posedge clk);
      #1 din = n;
   endtask

   task automatic clr();
      bq.delete();
      tq.delete();
      nblk = 0;
      ncerr = 0;
   endtask

   task automatic send_blk(input logic [31:0] data, input logic [3:0] pre, input logic flip,
                           input logic [1:0] fl, input logic [3:0] fbit, input logic [3:0] endn);
      logic [15:0] c[4];
      logic [3:0]  n, kk;
      for (int i = 0; i < 4; i++) c[i] = '0;
      step(4'hf); step(4'hf); step(pre); step(4'h0);
      for (int j = 0; j < 8; j++) begin
         n = data[31-4*j -: 4];
         step(n);
         for (int i = 0; i < 4; i++) c[i] = crc_step(c[i], n[i]);
      end
      if (flip) c[fl][fbit] = ~c[fl][fbit];
      for (int k = 0; k < 16; k++) begin
         kk = 4'(k);
         for (int i = 0; i < 4; i++) n[i] = c[i][~kk];
         step(n);
      end
      step(endn); step(4'hf); step(4'hf);
   endtask

   task automatic test_reset();
      rst = 1'b1; wr_en = 1'b0; busy_in = 1'b0; din = 4'hf;
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests++; if (byte_out !== 8'h00) begin fails++; $display("FAIL rst_byte_out got %h want 00", byte_out); end
      tests++; if (byte_vld !== 1'b0) begin fails++; $display("FAIL rst_byte_vld got %b want 0", byte_vld); end
      tests++; if (blk_done !== 1'b0) begin fails++; $display("FAIL rst_blk_done got %b want 0", blk_done); end
      tests++; if (crc_err !== 1'b0) begin fails++; $display("FAIL rst_crc_err got %b want 0", crc_err); end
      tests++; if (dout0 !== 1'b1) begin fails++; $display("FAIL rst_dout0 got %b want 1", dout0); end
      tests++; if (doe0 !== 1'b0) begin fails++; $display("FAIL rst_doe0 got %b want 0", doe0); end
      tests++; if (idle !== 1'b1) begin fails++; $display("FAIL rst_idle got %b want 1", idle); end
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_good_block();
      logic [7:0] exp_b [4];
      logic       exp_t [7];
      exp_b = '{8'h12, 8'h34, 8'h56, 8'h78};
      exp_t = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      clr();
      @(posedge clk); #1 wr_en = 1'b1;
      send_blk(32'h12345678, 4'hf, 1'b0, 2'd0, 4'd0, 4'hf);
      wr_en = 1'b0;
      repeat (25) @(posedge clk);
      tests++; if (bq.size() !== 4) begin fails++; $display("FAIL good_nbytes got %0d want 4", bq.size()); end
      for (int i = 0; i < 4 && i < bq.size(); i++) begin
         tests++; if (bq[i] !== exp_b[i]) begin fails++; $display("FAIL good_byte%0d got %h want %h", i, bq[i], exp_b[i]); end
      end
      tests++; if (nblk !== 1) begin fails++; $display("FAIL good_blk_done got %0d want 1", nblk); end
      tests++; if (ncerr !== 0) begin fails++; $display("FAIL good_crc_err got %0d want 0", ncerr); end
      tests++; if (tq.size() !== 7) begin fails++; $display("FAIL good_dat0_len got %0d want 7", tq.size()); end
      for (int i = 0; i < 7 && i < tq.size(); i++) begin
         tests++; if (tq[i] !== exp_t[i]) begin fails++; $display("FAIL good_dat0_bit%0d got %b want %b", i, tq[i], exp_t[i]); end
      end
      tests++; if (rel_dout !== 1'b1) begin fails++; $display("FAIL good_release_dout0 got %b want 1", rel_dout); end
      tests++; if (idle !== 1'b1) begin fails++; $display("FAIL good_idle_end got %b want 1", idle); end
   endtask

   task automatic test_crc_error(input logic flip, input logic [3:0] endn);
      logic exp_t [5];
      exp_t = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      clr();
      @(posedge clk); #1 wr_en = 1'b1;
      send_blk(32'h12345678, 4'hf, flip, 2'd2, 4'd7, endn);
      wr_en = 1'b0;
      repeat (25) @(posedge clk);
      tests++; if (nblk !== 1) begin fails++; $display("FAIL err%b_blk_done got %0d want 1", flip, nblk); end
      tests++; if (ncerr !== 1) begin fails++; $display("FAIL err%b_crc_err got %0d want 1", flip, ncerr); end
      tests++; if (tq.size() !== 5) begin fails++; $display("FAIL err%b_dat0_len got %0d want 5", flip, tq.size()); end
      for (int i = 0; i < 5 && i < tq.size(); i++) begin
         tests++; if (tq[i] !== exp_t[i]) begin fails++; $display("FAIL err%b_tok_bit%0d got %b want %b", flip, i, tq[i], exp_t[i]); end
      end
      tests++; if (rel_idle !== 1'b1) begin fails++; $display("FAIL err%b_idle_after_tok got %b want 1", flip, rel_idle); end
   endtask

   task automatic test_busy_multi();
      int k;
      clr();
      @(posedge clk); #1 wr_en = 1'b1;
      send_blk(32'h12345678, 4'hf, 1'b0, 2'd0, 4'd0, 4'hf);
      k = 0;
      while (tq.size() < 5 && k < 60) begin
         @(negedge clk); #1 k++;
      end
      if (k >= 60) begin tests++; fails++; $display("FAIL busy_wait_token got timeout want 5 token bits"); end
      @(posedge clk); #1 busy_in = 1'b1;
      repeat (10) @(posedge clk);
      #1 busy_in = 1'b0;
      repeat (3) @(posedge clk);
      tests++; if (tq.size() !== 15) begin fails++; $display("FAIL busy_dat0_len got %0d want 15", tq.size()); end
      for (int i = 5; i < tq.size(); i++) begin
         tests++; if (tq[i] !== 1'b0) begin fails++; $display("FAIL busy_low%0d got %b want 0", i, tq[i]); end
      end
      tests++; if (rel_dout !== 1'b1) begin fails++; $display("FAIL busy_release got %b want 1", rel_dout); end
      tests++; if (idle !== 1'b0) begin fails++; $display("FAIL busy_hunt_idle got %b want 0", idle); end
      clr();
      send_blk(32'hAAAAAAAA, 4'hf, 1'b0, 2'd0, 4'd0, 4'hf);
      wr_en = 1'b0;
      repeat (25) @(posedge clk);
      tests++; if (bq.size() !== 4) begin fails++; $display("FAIL blk2_nbytes got %0d want 4", bq.size()); end
      for (int i = 0; i < bq.size(); i++) begin
         tests++; if (bq[i] !== 8'hAA) begin fails++; $display("FAIL blk2_byte%0d got %h want aa", i, bq[i]); end
      end
      tests++; if (nblk !== 1 || ncerr !== 0) begin fails++; $display("FAIL blk2_done got %0d/%0d want 1/0", nblk, ncerr); end
      tests++; if (tq.size() !== 7) begin fails++; $display("FAIL blk2_dat0_len got %0d want 7", tq.size()); end
   endtask

   task automatic test_hunt_abort();
      logic [7:0] exp_b [3];
      exp_b = '{8'h12, 8'h34, 8'h56};
      clr();
      @(posedge clk); #1 wr_en = 1'b1;
      step(4'hf); step(4'hf); step(4'h8); step(4'h0);
      for (int j = 1; j <= 7; j++) step(4'(j));
      @(posedge clk); #1 din = 4'h8; wr_en = 1'b0;
      for (int j = 0; j < 30; j++) step(4'hf);
      tests++; if (bq.size() !== 3) begin fails++; $display("FAIL abort_nbytes got %0d want 3", bq.size()); end
      for (int i = 0; i < 3 && i < bq.size(); i++) begin
         tests++; if (bq[i] !== exp_b[i]) begin fails++; $display("FAIL abort_byte%0d got %h want %h", i, bq[i], exp_b[i]); end
      end
      tests++; if (nblk !== 0) begin fails++; $display("FAIL abort_blk_done got %0d want 0", nblk); end
      tests++; if (tq.size() !== 0) begin fails++; $display("FAIL abort_doe0_cycles got %0d want 0", tq.size()); end
      tests++; if (idle !== 1'b1) begin fails++; $display("FAIL abort_idle got %b want 1", idle); end
   endtask

   task automatic test_rst_in_stat();
      int k;
      clr();
      @(posedge clk); #1 wr_en = 1'b1;
      send_blk(32'h12345678, 4'hf, 1'b0, 2'd0, 4'd0, 4'hf);
      k = 0;
      while (tq.size() < 4 && k < 60) begin
         @(negedge clk); #1 k++;
      end
      if (k >= 60) begin tests++; fails++; $display("FAIL rst_stat_wait got timeout want 4 token bits"); end
      tests++; if (doe0 !== 1'b1) begin fails++; $display("FAIL rst_stat_pre_doe0 got %b want 1", doe0); end
      rst = 1'b1;
      @(negedge clk);
      tests++; if (doe0 !== 1'b0 || dout0 !== 1'b1) begin fails++; $display("FAIL rst_stat_dat0 got %b/%b want 0/1", doe0, dout0); end
      tests++; if (idle !== 1'b1) begin fails++; $display("FAIL rst_stat_idle got %b want 1", idle); end
      tests++; if ({byte_vld, blk_done, crc_err} !== 3'b000) begin fails++; $display("FAIL rst_stat_strobes got %b want 000", {byte_vld, blk_done, crc_err}); end
      @(posedge clk); #1 rst = 1'b0; wr_en = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   initial begin
      test_reset();
      test_good_block();
      test_crc_error(1'b1, 4'hf);
      test_crc_error(1'b0, 4'he);
      test_busy_multi();
      test_hunt_abort();
      test_rst_in_stat();
      tests++; if (nviol !== 0) begin fails++; $display("FAIL strobe_overlap got %0d want 0", nviol); end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
